// File: rtl/pgm_rd.sv
// Packet-generator read/output stage: forwards bypass traffic from pgm_wr, or replays
// the template packet held in PGM_RAM back-to-back with a programmable gap.
module pgm_rd #(
    parameter int         GAP  = 16,
    parameter logic [7:0] LMID = 8'd62
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1023:0] in_rd_phv,
    input  logic          in_rd_phv_wr,
    output logic          out_rd_phv_alf,
    input  logic [133:0]  in_rd_data,
    input  logic          in_rd_data_wr,
    input  logic          in_rd_valid,
    input  logic          in_rd_valid_wr,
    output logic          out_rd_alf,
    input  logic          pgm_bypass_flag,
    input  logic          pgm_sent_start_flag,
    input  logic          pgm_sent_finish_flag,
    output logic          rd2ram_rd_en,
    output logic [6:0]    rd2ram_addr,
    input  logic [143:0]  ram2rd_rdata,
    output logic [1023:0] out_rd_phv,
    output logic          out_rd_phv_wr,
    output logic [133:0]  out_rd_data,
    output logic          out_rd_data_wr,
    output logic          out_rd_valid,
    output logic          out_rd_valid_wr,
    input  logic          in_rd_phv_alf,
    input  logic          in_rd_alf,
    output logic [31:0]   gen_pkt_cnt,
    output logic [31:0]   drop_cnt,
    output logic          gen_err
);

    typedef enum logic [2:0] {IDLE, BYPASS, GEN_RD, GEN_GAP, GEN_STOP} state_t;

    localparam logic [15:0] GAP_END = 16'(GAP + 1);

    state_t      r_state;
    state_t      w_nxt;
    logic        r_start_d;
    logic        r_finish_d;
    logic        r_stop_req;
    logic        r_drop_pkt;
    logic        r_rd_vld_p1;
    logic [6:0]  r_addr;
    logic [6:0]  r_rd_addr_p1;
    logic [15:0] r_gap_cnt;

    logic        w_start_edge;
    logic        w_finish_edge;
    logic        w_gen;
    logic        w_in_head;
    logic        w_in_tail;
    logic        w_fwd;
    logic        w_fwd_data;
    logic        w_drop;
    logic [1:0]  w_ram_tag;
    logic        w_gen_word;
    logic        w_gen_head;
    logic        w_gen_tail;
    logic        w_gap_done;
    logic        w_unused;

    assign w_unused      = ^{pgm_bypass_flag, ram2rd_rdata[143:134], LMID};

    assign w_start_edge  = pgm_sent_start_flag & ~r_start_d;
    assign w_finish_edge = pgm_sent_finish_flag & ~r_finish_d;
    assign w_in_head     = (in_rd_data[133:132] == 2'b01);
    assign w_in_tail     = (in_rd_data[133:132] == 2'b10);
    assign w_ram_tag     = ram2rd_rdata[133:132];
    assign w_gap_done    = (r_gap_cnt >= GAP_END);

    // A returned word is only live while still in GEN_RD; the read issued on the tail cycle is discarded.
    assign w_gen_word = (r_state == GEN_RD) && r_rd_vld_p1;
    assign w_gen_head = w_gen_word && (w_ram_tag == 2'b01);
    assign w_gen_tail = w_gen_word && ((w_ram_tag == 2'b10) || (r_rd_addr_p1 == 7'd127));

    assign w_fwd_data = in_rd_data_wr &&
                        ((r_state == BYPASS) ||
                         ((r_state == IDLE) && !w_start_edge && w_in_head));
    assign w_fwd      = (r_state == BYPASS) ||
                        ((r_state == IDLE) && !w_start_edge && (!r_drop_pkt || w_fwd_data));
    assign w_drop     = in_rd_data_wr && !w_fwd_data;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_nxt;
    end

    always_comb begin
        w_nxt          = r_state;
        w_gen          = 1'b0;
        rd2ram_rd_en   = 1'b0;
        rd2ram_addr    = r_addr;
        case (r_state)
            IDLE: begin
                if (w_start_edge)
                    w_nxt = GEN_RD;
                else if (in_rd_data_wr && w_in_head)
                    w_nxt = BYPASS;
            end
            BYPASS: begin
                if (in_rd_data_wr && w_in_tail)
                    w_nxt = IDLE;
            end
            GEN_RD: begin
                w_gen        = 1'b1;
                rd2ram_rd_en = 1'b1;
                if (w_gen_tail)
                    w_nxt = GEN_GAP;
            end
            GEN_GAP: begin
                w_gen = 1'b1;
                if (w_finish_edge)
                    w_nxt = GEN_STOP;
                else if (w_gap_done) begin
                    if (r_stop_req)
                        w_nxt = GEN_STOP;
                    else if (!(in_rd_alf || in_rd_phv_alf))
                        w_nxt = GEN_RD;
                end
            end
            GEN_STOP: begin
                w_gen = 1'b1;
                w_nxt = IDLE;
            end
            default: w_nxt = IDLE;
        endcase
        out_rd_alf     = in_rd_alf | w_gen;
        out_rd_phv_alf = in_rd_phv_alf | w_gen;
    end

    // Control registers, read pipeline stage and statistics
    always_ff @(posedge clk) begin
        if (rst) begin
            r_start_d    <= 1'b0;
            r_finish_d   <= 1'b0;
            r_stop_req   <= 1'b0;
            r_drop_pkt   <= 1'b0;
            r_rd_vld_p1  <= 1'b0;
            r_rd_addr_p1 <= '0;
            r_addr       <= '0;
            r_gap_cnt    <= '0;
            gen_pkt_cnt  <= '0;
            drop_cnt     <= '0;
            gen_err      <= 1'b0;
        end else begin
            r_start_d    <= pgm_sent_start_flag;
            r_finish_d   <= pgm_sent_finish_flag;
            r_rd_vld_p1  <= (r_state == GEN_RD);
            r_rd_addr_p1 <= r_addr;
            r_addr       <= (r_state == GEN_RD) ? r_addr + 7'd1 : 7'd0;

            if (r_state != GEN_GAP)
                r_gap_cnt <= '0;
            else if (!w_gap_done)
                r_gap_cnt <= r_gap_cnt + 16'd1;

            if (w_nxt == IDLE)
                r_stop_req <= 1'b0;
            else if (w_finish_edge)
                r_stop_req <= 1'b1;

            // Remainder of a bypass packet whose head was dropped is dropped until its tail.
            if (w_fwd_data && w_in_head)
                r_drop_pkt <= 1'b0;
            else if (w_drop && w_in_head)
                r_drop_pkt <= 1'b1;
            else if (w_drop && w_in_tail)
                r_drop_pkt <= 1'b0;

            if (w_gen_tail)
                gen_pkt_cnt <= gen_pkt_cnt + 32'd1;
            if (w_drop)
                drop_cnt <= drop_cnt + 32'd1;
            if (w_gen_word && (r_rd_addr_p1 == 7'd127) && (w_ram_tag != 2'b10))
                gen_err <= 1'b1;
        end
    end

    // Output stage: registered, data zeroed whenever its strobe is low
    always_ff @(posedge clk) begin
        if (rst) begin
            out_rd_phv      <= '0;
            out_rd_phv_wr   <= 1'b0;
            out_rd_data     <= '0;
            out_rd_data_wr  <= 1'b0;
            out_rd_valid    <= 1'b0;
            out_rd_valid_wr <= 1'b0;
        end else begin
            out_rd_phv      <= '0;
            out_rd_phv_wr   <= 1'b0;
            out_rd_data     <= '0;
            out_rd_data_wr  <= 1'b0;
            out_rd_valid    <= 1'b0;
            out_rd_valid_wr <= 1'b0;
            if (w_gen_word) begin
                out_rd_data_wr  <= 1'b1;
                out_rd_data     <= {(w_gen_tail ? 2'b10 : w_ram_tag), ram2rd_rdata[131:0]};
                out_rd_phv_wr   <= w_gen_head;
                out_rd_valid_wr <= w_gen_tail;
                out_rd_valid    <= w_gen_tail;
            end else if (w_fwd) begin
                out_rd_data_wr  <= w_fwd_data;
                out_rd_data     <= w_fwd_data ? in_rd_data : 134'd0;
                out_rd_phv_wr   <= in_rd_phv_wr;
                out_rd_phv      <= in_rd_phv_wr ? in_rd_phv : 1024'd0;
                out_rd_valid_wr <= in_rd_valid_wr;
                out_rd_valid    <= in_rd_valid_wr ? in_rd_valid : 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pgm_rd.sv
// Directed bench for pgm_rd: bypass vector table, then generation, backpressure,
// drop, missing-tail and mid-packet reset sequences against a behavioural PGM_RAM.
module tb_pgm_rd;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1023:0] in_rd_phv = '0;
    logic          in_rd_phv_wr = 1'b0;
    logic          out_rd_phv_alf;
    logic [133:0]  in_rd_data = '0;
    logic          in_rd_data_wr = 1'b0;
    logic          in_rd_valid = 1'b0;
    logic          in_rd_valid_wr = 1'b0;
    logic          out_rd_alf;
    logic          pgm_bypass_flag = 1'b0;
    logic          pgm_sent_start_flag = 1'b0;
    logic          pgm_sent_finish_flag = 1'b0;
    logic          rd2ram_rd_en;
    logic [6:0]    rd2ram_addr;
    logic [143:0]  ram2rd_rdata = '0;
    logic [1023:0] out_rd_phv;
    logic          out_rd_phv_wr;
    logic [133:0]  out_rd_data;
    logic          out_rd_data_wr;
    logic          out_rd_valid;
    logic          out_rd_valid_wr;
    logic          in_rd_phv_alf = 1'b0;
    logic          in_rd_alf = 1'b0;
    logic [31:0]   gen_pkt_cnt;
    logic [31:0]   drop_cnt;
    logic          gen_err;

    pgm_rd #(.GAP(16), .LMID(8'd62)) dut (
        .clk(clk), .rst(rst),
        .in_rd_phv(in_rd_phv), .in_rd_phv_wr(in_rd_phv_wr), .out_rd_phv_alf(out_rd_phv_alf),
        .in_rd_data(in_rd_data), .in_rd_data_wr(in_rd_data_wr),
        .in_rd_valid(in_rd_valid), .in_rd_valid_wr(in_rd_valid_wr), .out_rd_alf(out_rd_alf),
        .pgm_bypass_flag(pgm_bypass_flag), .pgm_sent_start_flag(pgm_sent_start_flag),
        .pgm_sent_finish_flag(pgm_sent_finish_flag),
        .rd2ram_rd_en(rd2ram_rd_en), .rd2ram_addr(rd2ram_addr), .ram2rd_rdata(ram2rd_rdata),
        .out_rd_phv(out_rd_phv), .out_rd_phv_wr(out_rd_phv_wr),
        .out_rd_data(out_rd_data), .out_rd_data_wr(out_rd_data_wr),
        .out_rd_valid(out_rd_valid), .out_rd_valid_wr(out_rd_valid_wr),
        .in_rd_phv_alf(in_rd_phv_alf), .in_rd_alf(in_rd_alf),
        .gen_pkt_cnt(gen_pkt_cnt), .drop_cnt(drop_cnt), .gen_err(gen_err)
    );

    always #5 clk = ~clk;

    logic [133:0] mem [0:127];
    always @(posedge clk) if (rd2ram_rd_en) ram2rd_rdata <= {10'h0, mem[rd2ram_addr]};

    typedef struct {
        logic          dwr;
        logic [133:0]  d;
        logic          pwr;
        logic [1023:0] p;
        logic          vwr;
        logic          v;
        logic          alf_in;
        logic          e_dwr;
        logic [133:0]  e_d;
        logic          e_pwr;
        logic [1023:0] e_p;
        logic          e_vwr;
        logic          e_v;
        logic          e_alf;
    } vec_t;

    vec_t tbl [6];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [143:0] act, input logic [143:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int nh, nw, nv, h0, h1, nidle;
    logic [133:0] exp_w;

    initial begin
        for (int a = 0; a < 128; a++) mem[a] = {2'b11, 132'(a + 256)};
        mem[0] = {2'b01, 132'h100};
        mem[3] = {2'b10, 132'h103};

        tbl[0] = '{1'b0, 134'h0, 1'b0, 1024'h0, 1'b0, 1'b0, 1'b0,
                   1'b0, 134'h0, 1'b0, 1024'h0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, {2'b01, 132'hA0}, 1'b1, 1024'hBEEF, 1'b0, 1'b0, 1'b0,
                   1'b1, {2'b01, 132'hA0}, 1'b1, 1024'hBEEF, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, {2'b11, 132'hA1}, 1'b0, 1024'h0, 1'b0, 1'b0, 1'b1,
                   1'b1, {2'b11, 132'hA1}, 1'b0, 1024'h0, 1'b0, 1'b0, 1'b1};
        tbl[3] = '{1'b1, {2'b10, 132'hA2}, 1'b0, 1024'h0, 1'b1, 1'b1, 1'b0,
                   1'b1, {2'b10, 132'hA2}, 1'b0, 1024'h0, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b0, 134'h0, 1'b0, 1024'h0, 1'b0, 1'b0, 1'b0,
                   1'b0, 134'h0, 1'b0, 1024'h0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 134'h0, 1'b1, 1024'h5, 1'b0, 1'b0, 1'b0,
                   1'b0, 134'h0, 1'b1, 1024'h5, 1'b0, 1'b0, 1'b0};

        // reset state
        tick(); tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_data_wr", 144'(out_rd_data_wr), 144'(0));
        chk("rst_data", 144'(out_rd_data), 144'(0));
        chk("rst_phv_wr", 144'(out_rd_phv_wr), 144'(0));
        chk("rst_valid_wr", 144'(out_rd_valid_wr), 144'(0));
        chk("rst_rd_en", 144'(rd2ram_rd_en), 144'(0));
        chk("rst_addr", 144'(rd2ram_addr), 144'(0));
        chk("rst_gen_cnt", 144'(gen_pkt_cnt), 144'(0));
        chk("rst_drop_cnt", 144'(drop_cnt), 144'(0));
        chk("rst_gen_err", 144'(gen_err), 144'(0));
        chk("rst_alf", 144'(out_rd_alf), 144'(0));

        // bypass vectors
        pgm_bypass_flag = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_rd_data_wr  = tbl[i].dwr;
            in_rd_data     = tbl[i].d;
            in_rd_phv_wr   = tbl[i].pwr;
            in_rd_phv      = tbl[i].p;
            in_rd_valid_wr = tbl[i].vwr;
            in_rd_valid    = tbl[i].v;
            in_rd_alf      = tbl[i].alf_in;
            tick();
            chk($sformatf("bp%0d_data_wr", i), 144'(out_rd_data_wr), 144'(tbl[i].e_dwr));
            chk($sformatf("bp%0d_data", i), 144'(out_rd_data), 144'(tbl[i].e_d));
            chk($sformatf("bp%0d_phv_wr", i), 144'(out_rd_phv_wr), 144'(tbl[i].e_pwr));
            chk($sformatf("bp%0d_phv_eq", i), 144'(out_rd_phv === tbl[i].e_p), 144'(1));
            chk($sformatf("bp%0d_valid_wr", i), 144'(out_rd_valid_wr), 144'(tbl[i].e_vwr));
            chk($sformatf("bp%0d_valid", i), 144'(out_rd_valid), 144'(tbl[i].e_v));
            chk($sformatf("bp%0d_alf", i), 144'(out_rd_alf), 144'(tbl[i].e_alf));
        end
        in_rd_data_wr = 1'b0; in_rd_data = '0; in_rd_phv_wr = 1'b0; in_rd_phv = '0;
        in_rd_valid_wr = 1'b0; in_rd_valid = 1'b0; in_rd_alf = 1'b0; pgm_bypass_flag = 1'b0;
        tick();
        chk("bp_gen_cnt", 144'(gen_pkt_cnt), 144'(0));
        chk("bp_drop_cnt", 144'(drop_cnt), 144'(0));

        // basic generation: start at T, finish at T+40
        pgm_sent_start_flag = 1'b1;
        chk("gen_rd_en_T", 144'(rd2ram_rd_en), 144'(0));
        nh = 0; nw = 0; nv = 0; h0 = -1; h1 = -1;
        for (int i = 1; i <= 60; i++) begin
            tick();
            if (i == 1) begin
                chk("gen_rd_en_T1", 144'(rd2ram_rd_en), 144'(1));
                chk("gen_addr_T1", 144'(rd2ram_addr), 144'(0));
            end
            if (i == 10) pgm_sent_start_flag = 1'b0;
            if (i == 40) pgm_sent_finish_flag = 1'b1;
            if (out_rd_data_wr) begin
                chk("gen_word", 144'(out_rd_data), 144'(mem[nw % 4]));
                nw++;
            end
            if (out_rd_phv_wr) begin
                chk("gen_phv_zero", 144'(out_rd_phv != '0), 144'(0));
                if (nh == 0) h0 = i;
                else if (nh == 1) h1 = i;
                nh++;
            end
            if (out_rd_valid_wr) begin
                chk("gen_valid", 144'(out_rd_valid), 144'(1));
                nv++;
            end
        end
        pgm_sent_finish_flag = 1'b0;
        chk("gen_head0_cyc", 144'(h0), 144'(3));
        chk("gen_head1_cyc", 144'(h1), 144'(26));
        chk("gen_heads", 144'(nh), 144'(2));
        chk("gen_words", 144'(nw), 144'(8));
        chk("gen_tails", 144'(nv), 144'(2));
        chk("gen_cnt", 144'(gen_pkt_cnt), 144'(2));
        chk("gen_idle_alf", 144'(out_rd_alf), 144'(0));
        chk("gen_idle_rd_en", 144'(rd2ram_rd_en), 144'(0));

        // almost-full hold during the gap
        tick();
        pgm_sent_start_flag = 1'b1;
        nh = 0; h0 = -1; h1 = -1;
        for (int i = 1; i <= 90; i++) begin
            tick();
            if (i == 8) in_rd_alf = 1'b1;
            if (i == 12) pgm_sent_start_flag = 1'b0;
            if (i == 30) begin
                chk("alf_out_alf", 144'(out_rd_alf), 144'(1));
                chk("alf_out_phv_alf", 144'(out_rd_phv_alf), 144'(1));
            end
            if (i == 58) in_rd_alf = 1'b0;
            if (i == 62) pgm_sent_finish_flag = 1'b1;
            if (out_rd_phv_wr) begin
                if (nh == 0) h0 = i;
                else if (nh == 1) h1 = i;
                nh++;
            end
        end
        pgm_sent_finish_flag = 1'b0;
        chk("alf_head0_cyc", 144'(h0), 144'(3));
        chk("alf_head1_cyc", 144'(h1), 144'(61));
        chk("alf_heads", 144'(nh), 144'(2));
        chk("alf_gen_cnt", 144'(gen_pkt_cnt), 144'(4));
        chk("alf_idle", 144'(out_rd_alf), 144'(0));

        // bypass packet arriving during GEN_RD is dropped
        tick();
        pgm_sent_start_flag = 1'b1;
        nw = 0; nh = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (i == 2) begin
                in_rd_data_wr = 1'b1; in_rd_data = {2'b01, 132'hD0};
                pgm_sent_finish_flag = 1'b1;
                chk("drop_out_alf", 144'(out_rd_alf), 144'(1));
            end
            if (i == 3) in_rd_data = {2'b11, 132'hD1};
            if (i == 4) in_rd_data = {2'b10, 132'hD2};
            if (i == 5) begin in_rd_data_wr = 1'b0; in_rd_data = '0; end
            if (i == 6) begin pgm_sent_start_flag = 1'b0; pgm_sent_finish_flag = 1'b0; end
            if (out_rd_data_wr) begin
                chk("drop_gen_word", 144'(out_rd_data), 144'(mem[nw % 4]));
                nw++;
            end
            if (out_rd_phv_wr) nh++;
        end
        chk("drop_words", 144'(nw), 144'(4));
        chk("drop_heads", 144'(nh), 144'(1));
        chk("drop_cnt", 144'(drop_cnt), 144'(3));
        chk("drop_gen_cnt", 144'(gen_pkt_cnt), 144'(5));
        chk("drop_idle", 144'(out_rd_alf), 144'(0));

        // template without a tail: 128 words, last forced to tail
        mem[3] = {2'b11, 132'h103};
        tick();
        pgm_sent_start_flag = 1'b1;
        nw = 0; nv = 0;
        for (int i = 1; i <= 200; i++) begin
            tick();
            if (i == 2) pgm_sent_finish_flag = 1'b1;
            if (i == 6) begin pgm_sent_start_flag = 1'b0; pgm_sent_finish_flag = 1'b0; end
            if (out_rd_data_wr) begin
                exp_w = mem[nw % 128];
                if (nw == 127) exp_w = {2'b10, mem[127][131:0]};
                chk("nt_word", 144'(out_rd_data), 144'(exp_w));
                nw++;
            end
            if (out_rd_valid_wr) nv++;
        end
        chk("nt_words", 144'(nw), 144'(128));
        chk("nt_tails", 144'(nv), 144'(1));
        chk("nt_gen_err", 144'(gen_err), 144'(1));
        chk("nt_gen_cnt", 144'(gen_pkt_cnt), 144'(6));
        mem[3] = {2'b10, 132'h103};

        // reset while word 2 of 4 is on the output
        tick();
        pgm_sent_start_flag = 1'b1;
        for (int i = 1; i <= 4; i++) tick();
        chk("mr_word2_wr", 144'(out_rd_data_wr), 144'(1));
        chk("mr_word2", 144'(out_rd_data), 144'(mem[1]));
        rst = 1'b1;
        pgm_sent_start_flag = 1'b0;
        tick();
        chk("mr_data_wr", 144'(out_rd_data_wr), 144'(0));
        chk("mr_data", 144'(out_rd_data), 144'(0));
        chk("mr_valid_wr", 144'(out_rd_valid_wr), 144'(0));
        chk("mr_phv_wr", 144'(out_rd_phv_wr), 144'(0));
        chk("mr_gen_cnt", 144'(gen_pkt_cnt), 144'(0));
        chk("mr_drop_cnt", 144'(drop_cnt), 144'(0));
        chk("mr_gen_err", 144'(gen_err), 144'(0));
        chk("mr_rd_en", 144'(rd2ram_rd_en), 144'(0));
        chk("mr_alf", 144'(out_rd_alf), 144'(0));
        rst = 1'b0;
        nidle = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_rd_data_wr || out_rd_valid_wr || rd2ram_rd_en) nidle++;
        end
        chk("mr_stays_idle", 144'(nidle), 144'(0));
        chk("mr_gen_cnt_after", 144'(gen_pkt_cnt), 144'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
